fetch_stage: RTL and testbench

//  Instruction fetch stage directly downstream of the 16-bit PC register.

---
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: latches the PC, runs a req/ack read on instruction memory and
// presents the fetched word and its address to decode behind a valid/ready handshake.
module fetch_stage #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              pc_advance,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              fetch_err
);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_HOLD = 3'd2,
    S_DROP = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              ir_valid_q, ir_valid_d;
  logic [DATA_W-1:0] ir_data_q, ir_data_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              fetch_err_q, fetch_err_d;
  logic              timeout_hit;

  // This no-ack cycle is the ACK_TIMEOUT-th one of the current wait; 0 disables the check.
  assign timeout_hit = (ACK_TIMEOUT != 0) &&
                       (({1'b0, cnt_q} + 9'd1) == 9'(ACK_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      ir_valid_q  <= 1'b0;
      ir_data_q   <= '0;
      ir_pc_q     <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      ir_valid_q  <= ir_valid_d;
      ir_data_q   <= ir_data_d;
      ir_pc_q     <= ir_pc_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Next state and ack-wait counter; an ack arriving on the limit cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!flush) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          state_d = flush ? S_IDLE : S_HOLD;
        end else if (flush) begin
          state_d = S_DROP;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (ir_ready) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs follow the next state; the address is captured only on entering REQ.
  always_comb begin
    imem_req_d  = (state_d == S_REQ) || (state_d == S_DROP);
    ir_valid_d  = (state_d == S_HOLD);
    fetch_err_d = (state_d == S_ERR);
    imem_addr_d = imem_addr_q;
    ir_data_d   = ir_data_q;
    ir_pc_d     = ir_pc_q;
    pc_advance  = 1'b0;
    if (((state_q == S_IDLE) || (state_q == S_HOLD)) && (state_d == S_REQ)) begin
      imem_addr_d = pc;
    end
    if ((state_q == S_REQ) && imem_ack && !flush) begin
      pc_advance = 1'b1;
      ir_data_d  = imem_rdata;
      ir_pc_d    = imem_addr_q;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign ir_valid  = ir_valid_q;
  assign ir_data   = ir_data_q;
  assign ir_pc     = ir_pc_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the bench plays PC register, instruction memory and decode.
module tb_fetch_stage;
  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        flush;
  logic        pc_advance;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        fetch_err;

  fetch_stage #(.ADDR_W(16), .DATA_W(16), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .pc_advance(pc_advance),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_data(ir_data), .ir_pc(ir_pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  time         cons_t[$];
  int          cons_n = 0;

  // driver-side environment state
  logic        p_adv, p_flush, p_ack;
  logic [15:0] p_target, target, flush_tgt;
  bit          in_txn, no_ack, flush_req;
  int          wait_left;
  int          lat_fix = -1;
  int          force_ready = -1;
  int          flush_pct = 0;

  // monitor-side reference state
  logic        prev_req, prev_ack;
  logic [15:0] prev_pc, txn_addr;
  int unsigned run;
  bit          txn_fl, err_exp;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'hA5A5;
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Architectural instruction stream restarts at a new address: consecutive words from there.
  task automatic refill(input logic [15:0] start);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) exp_q.push_back(16'(start + 16'(i)));
  endtask

  task automatic apply_reset(input logic [15:0] start);
    rst = 1'b1; pc = start; flush = 1'b0; imem_ack = 1'b0; ir_ready = 1'b0;
    imem_rdata = '0; in_txn = 1'b0; flush_req = 1'b0;
    p_adv = 1'b0; p_flush = 1'b0; p_ack = 1'b0; p_target = '0;
    refill(start);
    @(negedge clk); #3;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(ir_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_data", 32'(ir_data), 32'd0);
    chk("rst_irpc", 32'(ir_pc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle of environment: PC register update, memory response, decode ready, redirects.
  task automatic tick();
    @(negedge clk);
    if (p_flush) pc = p_target;
    else if (p_adv) pc = pc + 16'd1;
    if (p_ack) in_txn = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 16'($urandom);
    if (imem_req && !no_ack) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        wait_left = (lat_fix >= 0) ? lat_fix : int'($urandom_range(3, 0));
      end
      if (wait_left == 0) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        wait_left--;
      end
    end
    ir_ready = (force_ready >= 0) ? (force_ready > 0) : ($urandom_range(99, 0) < 60);
    flush = 1'b0;
    if (flush_req) begin
      flush = 1'b1; target = flush_tgt; flush_req = 1'b0;
    end else if (flush_pct > 0 && $urandom_range(99, 0) < flush_pct) begin
      flush = 1'b1; target = 16'($urandom);
    end
    if (flush) refill(target);
    #1;
    p_adv = pc_advance; p_flush = flush; p_target = target; p_ack = imem_req & imem_ack;
  endtask

  // Monitor: samples what the coming edge will see and checks against the reference.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        run = 0; txn_fl = 1'b0; err_exp = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
      end else begin
        chk("fetch_err", 32'(fetch_err), 32'(err_exp));
        chk("pc_advance", 32'(pc_advance), 32'(imem_req & imem_ack & ~flush & ~txn_fl));
        if (err_exp) begin
          chk("err_req", 32'(imem_req), 32'd0);
          chk("err_valid", 32'(ir_valid), 32'd0);
        end
        if (imem_req) begin
          if (!prev_req || prev_ack) txn_addr = prev_pc;
          chk("imem_addr", 32'(imem_addr), 32'(txn_addr));
        end
        if (ir_valid && !flush) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty actual=ir_pc %0h required=no instruction", ir_pc);
          end else begin
            chk("ir_pc", 32'(ir_pc), 32'(exp_q[0]));
            chk("ir_data", 32'(ir_data), 32'(mem_word(exp_q[0])));
            if (ir_ready) begin
              void'(exp_q.pop_front());
              cons_t.push_back($time);
              cons_n++;
            end
          end
        end
        if (imem_req) begin
          if (imem_ack) begin
            run = 0; txn_fl = 1'b0;
          end else if (flush && !txn_fl) begin
            txn_fl = 1'b1; run = 0;
          end else begin
            run++;
            if (run == TMO) err_exp = 1'b1;
          end
        end
      end
      prev_req = imem_req; prev_ack = imem_ack; prev_pc = pc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=no finish required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, adv, rc, vc, base;
    rst = 1'b1; pc = '0; flush = 1'b0; imem_ack = 1'b0; imem_rdata = '0; ir_ready = 1'b0;
    no_ack = 1'b0; target = '0; flush_tgt = '0; wait_left = 0;

    // T1: single fetch with one wait cycle
    apply_reset(16'h0010); lat_fix = 1; force_ready = 1;
    n = 0; while (!imem_req && n < 10) begin tick(); n++; end
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", 32'(imem_addr), 32'h0010);
    adv = 0; n = 0;
    while (!ir_valid && n < 10) begin tick(); adv += int'(p_adv); n++; end
    chk("t1_adv", 32'(adv), 32'd1);
    chk("t1_data", 32'(ir_data), 32'hA5A5);
    chk("t1_irpc", 32'(ir_pc), 32'h0010);
    n = 0; while (!imem_req && n < 10) begin tick(); n++; end
    chk("t1_next_addr", 32'(imem_addr), 32'h0011);

    // T2: zero-wait memory across the address wrap, one instruction every two cycles
    apply_reset(16'hFFFE); lat_fix = 0; force_ready = 1;
    base = cons_n; n = 0;
    while (cons_n < base + 4 && n < 40) begin tick(); n++; end
    chk("t2_count", 32'(cons_n >= base + 4), 32'd1);
    for (int k = 1; k < 4 && base + k < cons_n; k++)
      chk("t2_gap", 32'(cons_t[base + k] - cons_t[base + k - 1]), 32'd20);

    // T3: decode stalls for five cycles
    force_ready = 0;
    n = 0; while (!ir_valid && n < 10) begin tick(); n++; end
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_valid", 32'(ir_valid), 32'd1);
      chk("t3_req", 32'(imem_req), 32'd0);
      chk("t3_adv", 32'(p_adv), 32'd0);
    end

    // T4: redirect while the read is outstanding
    force_ready = 1; lat_fix = 3;
    n = 0; while (!imem_req && n < 10) begin tick(); n++; end
    flush_req = 1'b1; flush_tgt = 16'h0200;
    rc = 0; adv = 0; vc = 0; n = 0;
    do begin
      tick(); n++;
      if (imem_req) rc++;
      adv += int'(p_adv); vc += int'(ir_valid);
    end while (imem_req && n < 20);
    chk("t4_req_cycles", 32'(rc), 32'd3);
    chk("t4_adv", 32'(adv), 32'd0);
    chk("t4_valid", 32'(vc), 32'd0);
    n = 0; while (!imem_req && n < 10) begin tick(); n++; end
    chk("t4_next_addr", 32'(imem_addr), 32'h0200);

    // T5: redirect and decode-ready in the same HOLD cycle
    force_ready = 0; lat_fix = 0;
    n = 0; while (!ir_valid && n < 10) begin tick(); n++; end
    force_ready = 1; flush_req = 1'b1; flush_tgt = 16'h0300;
    tick(); tick();
    chk("t5_valid", 32'(ir_valid), 32'd0);
    n = 0; while (!imem_req && n < 10) begin tick(); n++; end
    chk("t5_next_addr", 32'(imem_addr), 32'h0300);
    n = 0; while (!ir_valid && n < 10) begin tick(); n++; end
    chk("t5_irpc", 32'(ir_pc), 32'h0300);

    // Randomized traffic: memory latency, decode stalls and redirects
    force_ready = -1; lat_fix = -1; flush_pct = 8;
    repeat (600) tick();
    flush_pct = 0;

    // T6: memory never answers
    force_ready = 0; lat_fix = 0;
    n = 0; while (!ir_valid && n < 20) begin tick(); n++; end
    chk("t6_hold", 32'(ir_valid), 32'd1);
    no_ack = 1'b1; force_ready = 1;
    rc = 0; n = 0;
    while (!fetch_err && n < 30) begin tick(); if (imem_req) rc++; n++; end
    chk("t6_err", 32'(fetch_err), 32'd1);
    chk("t6_wait_cycles", 32'(rc), 32'(TMO));
    no_ack = 1'b0;
    repeat (3) begin
      tick();
      chk("t6_sticky", 32'(fetch_err), 32'd1);
      chk("t6_noreq", 32'(imem_req), 32'd0);
    end

    // Asynchronous reset in the middle of an outstanding request
    apply_reset(16'h0400); no_ack = 1'b1;
    n = 0; while (!imem_req && n < 10) begin tick(); n++; end
    chk("t6_req_before_rst", 32'(imem_req), 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_req", 32'(imem_req), 32'd0);
    chk("t6_rst_addr", 32'(imem_addr), 32'd0);
    apply_reset(16'h0400); no_ack = 1'b0; lat_fix = -1; force_ready = 1;
    n = 0; while (!ir_valid && n < 20) begin tick(); n++; end
    chk("t6_recover_irpc", 32'(ir_pc), 32'h0400);
    chk("t6_recover_data", 32'(ir_data), 32'(mem_word(16'h0400)));
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
